// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load-use interlock, taken-branch flush and
// a saturating load-use stall counter. All control outputs are decoded
// combinationally from the registered state, the pending-load tracker and
// the current inputs.
module id_hazard_ctrl #(
    parameter logic [3:0]  LOAD_OPC     = 4'b1010,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_valid,
    input  logic [3:0] opcode,
    input  logic [3:0] one,
    input  logic [3:0] two,
    input  logic [3:0] three,
    input  logic       ex_ready,
    input  logic       branch_taken,
    input  logic       load_done,
    output logic       id_valid,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       bubble,
    output logic       flush,
    output logic [7:0] stall_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        LOAD_WAIT = 2'b01,
        FLUSH     = 2'b10
    } stateT;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    stateT      curState;
    logic       pendValid;
    logic [3:0] pendReg;
    logic [3:0] flushCnt;
    logic [7:0] stallCnt;

    logic useOne;
    logic useTwo;
    logic useThree;
    logic hazard;
    logic loadIssue;
    logic stallCycle;

    // Decode which operand fields the instruction in ID reads as sources.
    always_comb begin
        useOne   = 1'b0;
        useTwo   = 1'b0;
        useThree = 1'b0;
        case (opcode)
            4'b0100, 4'b0101, 4'b0110: useOne = 1'b1;
            4'b1000, 4'b1011: begin
                useOne = 1'b1;
                useTwo = 1'b1;
            end
            4'b1100, 4'b1111: ;
            default: begin
                useTwo   = 1'b1;
                useThree = 1'b1;
            end
        endcase
    end

    // Load-use hazard against the outstanding load destination.
    always_comb begin
        hazard = pendValid && if_valid &&
                 ((useOne   && (one   == pendReg)) ||
                  (useTwo   && (two   == pendReg)) ||
                  (useThree && (three == pendReg)));
    end

    // Pipeline control outputs; branch_taken overrides every state.
    always_comb begin
        id_valid   = 1'b0;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        if (rst) begin
            // all control outputs held low while in reset
        end else if (branch_taken) begin
            flush      = 1'b1;
            bubble     = 1'b1;
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end else begin
            case (curState)
                FLUSH: begin
                    flush      = 1'b1;
                    bubble     = 1'b1;
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
                LOAD_WAIT: bubble = 1'b1;
                default: begin
                    if (hazard) begin
                        bubble = 1'b1;
                    end else begin
                        id_valid   = if_valid;
                        pc_write   = ex_ready;
                        ifid_write = ex_ready;
                    end
                end
            endcase
        end
    end

    // Qualifiers for the tracker and the stall counter.
    always_comb begin
        loadIssue  = id_valid && ex_ready && (opcode == LOAD_OPC);
        stallCycle = !branch_taken &&
                     ((curState == LOAD_WAIT) ||
                      ((curState != LOAD_WAIT) && (curState != FLUSH) && hazard));
    end

    assign stall_count = stallCnt;
    assign state       = curState;

    // State, pending-load tracker, flush counter and stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curState  <= RUN;
            pendValid <= 1'b0;
            pendReg   <= '0;
            flushCnt  <= '0;
            stallCnt  <= '0;
        end else begin
            if (stallCycle && (stallCnt != 8'hFF)) begin
                stallCnt <= stallCnt + 8'd1;
            end

            // A load issuing in the same cycle as a clear still leaves a pending load.
            if (loadIssue) begin
                pendValid <= 1'b1;
                pendReg   <= one;
            end else if (load_done || branch_taken) begin
                pendValid <= 1'b0;
            end

            if (branch_taken) begin
                curState <= FLUSH;
                flushCnt <= FLUSH_RELOAD;
            end else begin
                case (curState)
                    FLUSH: begin
                        if (flushCnt == 4'd0) begin
                            curState <= RUN;
                        end else begin
                            flushCnt <= flushCnt - 4'd1;
                        end
                    end
                    LOAD_WAIT: begin
                        if (load_done) begin
                            curState <= RUN;
                        end
                    end
                    default: begin
                        // Unused encoding falls into RUN behaviour and is forced back to RUN.
                        if (hazard && !load_done) begin
                            curState <= LOAD_WAIT;
                        end else begin
                            curState <= RUN;
                        end
                    end
                endcase
            end
        end
    end

endmodule
